led_scan_disp: RTL and testbench
================================

// Module: led_scan_disp
// PURPOSE
//  Parametrised time-multiplexed 7-segment driver: scans DIGITS hex digits onto one
//  shared segment bus plus decimal point, one digit-select line per digit. Adds internal
//  scan prescaler, inter-digit blanking (anti-ghosting), frame-synchronous double-buffered
//  load, leading-zero suppression and selectable drive polarity. Sits between counter/
//  datapath outputs and the board LED pins.
// PARAMETERS
//  DIGITS      4  number of digits scanned (2..8)
//  DIV         1  CP cycles per scan tick (1 => tick every CP; 50000 for 50MHz->1kHz)
//  SLOT_TICKS  1  scan ticks each digit is selected (>=1)
//  BLANK_TICKS 0  leading ticks of each slot with all selects inactive (< SLOT_TICKS)
//  SEG_ACT_LO  1  1: segment/DP lit by 0 (gfedcba, '0' = 7'b1000000); 0: lit by 1
//  SG_ACT_HI   1  1: digit select active-high; 0: active-low
//  LZ_SUPP     0  1: blank leading zeros
// PORTS
//  CP      in  1         clock
//  nCR     in  1         reset, asynchronous, active-low
//  BCD     in  4*DIGITS  digit codes; BCD[3:0] = digit 0 = leftmost/most significant
//  DP      in  DIGITS    decimal point per digit; DP[0] = digit 0
//  Load    in  1         capture BCD/DP into pending buffer this cycle
//  Segout  out 7         segment code, {g,f,e,d,c,b,a}
//  DPout   out 1         decimal point
//  SG      out DIGITS    digit selects; SG[0] drives digit 0
//  Frame   out 1         one-CP pulse when display buffer is updated (frame boundary)
// BEHAVIOUR
//  One clock (CP); reset asynchronous, active-low (nCR). All outputs registered.
//  Reset: prescaler, slot counter, digit index = 0; pending/display buffers = 0, pend flag
//   = 0; SG all inactive; Segout, DPout = unlit; Frame = 0. Normal scan resumes at digit 0
//   after nCR deasserts; no partial outputs while nCR low.
//  Tick: prescaler counts 0..DIV-1, tick on DIV-1 then wraps to 0; DIV=1 => every cycle.
//  Slot: slot counter 0..SLOT_TICKS-1 advanced on tick; on wrap, digit index increments,
//   DIGITS-1 -> 0 (frame boundary = tick that wraps index to 0).
//  Outputs update the CP cycle after a tick (latency 1): if slot count < BLANK_TICKS, SG all
//   inactive and Segout/DPout unlit; else SG one-hot on current index, Segout = decode of
//   display digit, DPout = display DP bit. Never two selects active simultaneously.
//  Load: captures BCD/DP into pending, sets pend. At frame boundary with pend=1: pending ->
//   display buffer, pend cleared, Frame pulses 1 cycle. No pend => no copy, no Frame.
//   Load coincident with frame boundary: new BCD/DP written directly to display, pend
//   cleared, Frame pulses. Multiple Loads within a frame: last one wins.
//  Decode (active-high gfedcba; inverted when SEG_ACT_LO=1): 0 3F, 1 06, 2 5B, 3 4F, 4 66,
//   5 6D, 6 7D, 7 07, 8 7F, 9 6F, A 77, b 7C, C 39, d 5E, E 79, F 71. All 16 codes defined.
//  LZ_SUPP=1: digit k (k<DIGITS-1) segments unlit if display digits 0..k all zero; digit
//   DIGITS-1 always shown ("0" displayed for all-zero value). DP unaffected by suppression.
//  Polarity: inactive SG level = ~SG_ACT_HI; unlit segment level = SEG_ACT_LO.
//  Width rules: counters sized by $clog2 of their modulus (min 1 bit); all wrap explicitly.
// STRUCTURE
//  led_disp_defs.vh: SEG_* 7-bit active-high codes 0-F, SEG_BLANK, select polarity macros.
//  Sub-module seg7_hex_dec: 4-bit code -> 7-bit active-high segments, combinational.
//  Top: prescaler, slot/index counters, pending/display buffers, LZ logic, output regs.
// TESTING
//  Reset: nCR low mid-scan -> SG=0000, Segout=7'h7F, DPout=1, Frame=0 immediately (async).
//  Scan, DIGITS=4, DIV=1, SLOT=1: Load BCD=16'h3210 -> after Frame, SG 1000,0100,0010,0001
//   cyclic (SG[0]..SG[3]) with Segout 40h,79h,24h,30h.
//  Prescale/blank, DIV=4, SLOT=4, BLANK=1: each digit selected 12 CP, preceded by 4 CP
//   all-off; full frame = 64 CP.
//  Double buffer: Load 16'h1111 mid-frame -> displayed values unchanged until boundary, then
//   Frame pulse; Load on boundary cycle -> takes effect that frame; no Load -> no Frame.
//  LZ_SUPP=1, BCD=16'h0500 (digit0=0,digit1=0,digit2=5,digit3=0) -> digits 0,1 unlit,
//   digit2 12h, digit3 40h; BCD=0 -> only digit3 shows 40h; DP[0]=1 still lights DP.
//  Polarity SEG_ACT_LO=0, SG_ACT_HI=0, code 8 -> Segout=7Fh, active SG bit 0, others 1.

Source files
------------

// File: rtl/led_scan_disp_pkg.sv
// led_scan_disp_pkg: segment code table and counter sizing helper for the LED scanner
package led_scan_disp_pkg;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  function automatic int cw(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/led_scan_disp_dec.sv
// led_scan_disp_dec: 4-bit hex code to active-high gfedcba segments
module led_scan_disp_dec
  import led_scan_disp_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);
  assign seg = SEG_TAB[code];
endmodule

// File: rtl/led_scan_disp.sv
// led_scan_disp: time-multiplexed 7-segment scanner with blanking, double buffer and zero suppression
module led_scan_disp
  import led_scan_disp_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int DIV         = 1,
  parameter int SLOT_TICKS  = 1,
  parameter int BLANK_TICKS = 0,
  parameter bit SEG_ACT_LO  = 1'b1,
  parameter bit SG_ACT_HI   = 1'b1,
  parameter bit LZ_SUPP     = 1'b0
) (
  input  logic                  CP,
  input  logic                  nCR,
  input  logic [4*DIGITS-1:0]   BCD,
  input  logic [DIGITS-1:0]     DP,
  input  logic                  Load,
  output logic [6:0]            Segout,
  output logic                  DPout,
  output logic [DIGITS-1:0]     SG,
  output logic                  Frame
);
  localparam int PW = cw(DIV);
  localparam int SW = cw(SLOT_TICKS);
  localparam int IW = cw(DIGITS);
  localparam logic [DIGITS-1:0] SG_OFF = {DIGITS{~SG_ACT_HI}};
  localparam logic [6:0] SEG_OFF = {7{SEG_ACT_LO}};
  logic [PW-1:0] pre;
  logic [SW-1:0] slot;
  logic [IW-1:0] idx;
  logic [4*DIGITS-1:0] pend_bcd, disp_bcd;
  logic [DIGITS-1:0] pend_dp, disp_dp, lz;
  logic pend, tick, slot_end, frame_end, upd, blank, hide, z;
  logic [6:0] seg;
  assign tick = pre == PW'(DIV - 1);
  assign slot_end = tick && slot == SW'(SLOT_TICKS - 1);
  assign frame_end = slot_end && idx == IW'(DIGITS - 1);
  assign upd = frame_end && (Load || pend);
  assign blank = int'(slot) < BLANK_TICKS;
  assign hide = blank || (LZ_SUPP && lz[idx]);
  led_scan_disp_dec u_dec (.code(disp_bcd[{idx, 2'b00} +: 4]), .seg(seg));
  // running all-zero prefix over display digits; the last digit is never hidden
  always_comb begin
    lz = '0;
    z = 1'b1;
    for (int k = 0; k < DIGITS - 1; k++) begin
      z = z && disp_bcd[4*k +: 4] == 4'h0;
      lz[k] = z;
    end
  end
  // prescaler, slot counter and digit index
  always_ff @(posedge CP or negedge nCR)
    if (!nCR) begin
      pre <= '0;
      slot <= '0;
      idx <= '0;
    end else begin
      pre <= tick ? '0 : pre + 1'b1;
      if (tick) slot <= slot_end ? '0 : slot + 1'b1;
      if (slot_end) idx <= frame_end ? '0 : idx + 1'b1;
    end
  // pending capture and frame-synchronous transfer into the display buffer
  always_ff @(posedge CP or negedge nCR)
    if (!nCR) begin
      pend_bcd <= '0;
      pend_dp <= '0;
      disp_bcd <= '0;
      disp_dp <= '0;
      pend <= 1'b0;
      Frame <= 1'b0;
    end else begin
      if (Load) pend_bcd <= BCD;
      if (Load) pend_dp <= DP;
      if (upd) disp_bcd <= Load ? BCD : pend_bcd;
      if (upd) disp_dp <= Load ? DP : pend_dp;
      pend <= frame_end ? 1'b0 : pend || Load;
      Frame <= upd;
    end
  // registered pin drive, one cycle behind the scan counters
  always_ff @(posedge CP or negedge nCR)
    if (!nCR) begin
      SG <= SG_OFF;
      Segout <= SEG_OFF;
      DPout <= SEG_ACT_LO;
    end else begin
      SG <= blank ? SG_OFF : SG_OFF ^ (DIGITS'(1) << idx);
      Segout <= (hide ? SEG_BLANK : seg) ^ SEG_OFF;
      DPout <= (!blank && disp_dp[idx]) ^ SEG_ACT_LO;
    end
endmodule

// File: tb/tb_led_scan_disp.sv
// tb_led_scan_disp: three scanner configurations checked against a time-based reference model
module tb_led_scan_disp;
  localparam int ND = 3;
  localparam int DIV_P [ND] = '{1, 4, 1};
  localparam int SLT_P [ND] = '{1, 4, 2};
  localparam int BLK_P [ND] = '{0, 1, 0};
  localparam bit LO_P [ND] = '{1'b1, 1'b1, 1'b0};
  localparam bit HI_P [ND] = '{1'b1, 1'b1, 1'b0};
  localparam bit LZ_P [ND] = '{1'b0, 1'b1, 1'b0};
  localparam logic [6:0] SEGS [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  typedef struct packed { logic [3:0] sg; logic dp; logic [6:0] seg; } out_t;
  typedef struct packed { logic [15:0] bcd; logic [3:0] dp; logic [3:0][6:0] seg; } vec_t;
  logic CP = 1'b0, nCR, Load;
  logic [15:0] BCD;
  logic [3:0] DP;
  logic [6:0] seg [ND];
  logic dpo [ND], frm [ND];
  logic [3:0] sg [ND];
  int n_chk, n_fail, edges;
  logic [15:0] m_disp [ND], m_pend [ND];
  logic [3:0] m_ddp [ND], m_pdp [ND];
  bit m_pf [ND];
  logic [6:0] cap_seg [4];
  logic cap_dp [4];
  int cap_n [5];
  vec_t tbl [4];
  int nfr;

  always #5 CP = ~CP;

  led_scan_disp #(.DIGITS(4)) u0 (.CP(CP), .nCR(nCR), .BCD(BCD), .DP(DP), .Load(Load),
    .Segout(seg[0]), .DPout(dpo[0]), .SG(sg[0]), .Frame(frm[0]));
  led_scan_disp #(.DIGITS(4), .DIV(4), .SLOT_TICKS(4), .BLANK_TICKS(1), .LZ_SUPP(1'b1)) u1 (
    .CP(CP), .nCR(nCR), .BCD(BCD), .DP(DP), .Load(Load),
    .Segout(seg[1]), .DPout(dpo[1]), .SG(sg[1]), .Frame(frm[1]));
  led_scan_disp #(.DIGITS(4), .SLOT_TICKS(2), .SEG_ACT_LO(1'b0), .SG_ACT_HI(1'b0)) u2 (
    .CP(CP), .nCR(nCR), .BCD(BCD), .DP(DP), .Load(Load),
    .Segout(seg[2]), .DPout(dpo[2]), .SG(sg[2]), .Frame(frm[2]));

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // expected pins after an edge, from the number of edges seen before it
  function automatic out_t ref_out(int i, int e);
    out_t o;
    int t = e / DIV_P[i];
    int s = t % SLT_P[i];
    int d = (t / SLT_P[i]) % 4;
    bit blank = s < BLK_P[i];
    bit sup = LZ_P[i] && d < 3;
    logic [6:0] lit;
    for (int k = 0; k <= d; k++) if (m_disp[i][4*k +: 4] != 4'h0) sup = 1'b0;
    lit = (blank || sup) ? 7'h00 : SEGS[m_disp[i][4*d +: 4]];
    o.seg = LO_P[i] ? ~lit : lit;
    o.dp = (blank ? 1'b0 : m_ddp[i][d]) ^ LO_P[i];
    o.sg = blank ? 4'h0 : 4'(1) << d;
    if (!HI_P[i]) o.sg = ~o.sg;
    return o;
  endfunction

  task automatic model_reset();
    edges = 0;
    for (int i = 0; i < ND; i++) begin
      m_disp[i] = '0; m_pend[i] = '0; m_ddp[i] = '0; m_pdp[i] = '0; m_pf[i] = 1'b0;
    end
  endtask

  task automatic check_reset();
    for (int i = 0; i < ND; i++) begin
      check($sformatf("u%0d reset seg", i), seg[i], LO_P[i] ? 7'h7F : 7'h00);
      check($sformatf("u%0d reset dp", i), dpo[i], LO_P[i]);
      check($sformatf("u%0d reset sg", i), sg[i], HI_P[i] ? 4'h0 : 4'hF);
      check($sformatf("u%0d reset frame", i), frm[i], 0);
    end
  endtask

  task automatic step();
    out_t ex [ND];
    bit bnd, efr;
    for (int i = 0; i < ND; i++) ex[i] = ref_out(i, edges);
    @(posedge CP); #1;
    edges++;
    for (int i = 0; i < ND; i++) begin
      bnd = edges % (DIV_P[i] * SLT_P[i] * 4) == 0;
      efr = bnd && (Load || m_pf[i]);
      if (bnd && Load) begin m_disp[i] = BCD; m_ddp[i] = DP; m_pf[i] = 1'b0; end
      else if (bnd && m_pf[i]) begin m_disp[i] = m_pend[i]; m_ddp[i] = m_pdp[i]; m_pf[i] = 1'b0; end
      else if (Load) begin m_pend[i] = BCD; m_pdp[i] = DP; m_pf[i] = 1'b1; end
      check($sformatf("u%0d seg", i), seg[i], ex[i].seg);
      check($sformatf("u%0d dp", i), dpo[i], ex[i].dp);
      check($sformatf("u%0d sg", i), sg[i], ex[i].sg);
      check($sformatf("u%0d frame", i), frm[i], efr);
    end
  endtask

  task automatic wait_frame(int i, int budget);
    int n = 0;
    while (!frm[i] && n < budget) begin step(); n++; end
    check($sformatf("u%0d frame seen", i), frm[i], 1);
  endtask

  task automatic scan_u1();
    for (int k = 0; k < 5; k++) cap_n[k] = 0;
    for (int k = 0; k < 4; k++) begin cap_seg[k] = 'x; cap_dp[k] = 1'bx; end
    for (int j = 0; j < 64; j++) begin
      step();
      if (sg[1] == 4'h0) cap_n[4]++;
      for (int k = 0; k < 4; k++)
        if (sg[1] == 4'(1) << k) begin cap_n[k]++; cap_seg[k] = seg[1]; cap_dp[k] = dpo[1]; end
    end
    check("u1 blank cycles", cap_n[4], 16);
    for (int k = 0; k < 4; k++) check($sformatf("u1 digit%0d cycles", k), cap_n[k], 12);
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    nCR = 1'b0; Load = 1'b0; BCD = '0; DP = '0;
    model_reset();
    tbl[0] = '{bcd: 16'h3210, dp: 4'b0001, seg: {7'h30, 7'h24, 7'h79, 7'h40}};
    tbl[1] = '{bcd: 16'h7654, dp: 4'b1010, seg: {7'h78, 7'h02, 7'h12, 7'h19}};
    tbl[2] = '{bcd: 16'hBA98, dp: 4'b0100, seg: {7'h03, 7'h08, 7'h10, 7'h00}};
    tbl[3] = '{bcd: 16'hFEDC, dp: 4'b1111, seg: {7'h0E, 7'h06, 7'h21, 7'h46}};
    #12;
    check_reset();
    #1 nCR = 1'b1;
    repeat (10) step();
    for (int v = 0; v < 4; v++) begin
      BCD = tbl[v].bcd; DP = tbl[v].dp; Load = 1'b1;
      step();
      Load = 1'b0;
      wait_frame(0, 20);
      for (int k = 0; k < 4; k++) begin
        step();
        check("tbl seg", seg[0], tbl[v].seg[k]);
        check("tbl sg", sg[0], 4'(1) << k);
        check("tbl dp", dpo[0], !tbl[v].dp[k]);
      end
    end
    for (int j = 0; j < 400; j++) begin
      Load = $urandom_range(0, 5) == 0;
      BCD = 16'($urandom);
      DP = 4'($urandom);
      step();
    end
    Load = 1'b0;
    BCD = 16'h0500; DP = 4'b0001; Load = 1'b1;
    step();
    Load = 1'b0;
    wait_frame(1, 100);
    scan_u1();
    check("lz d0 seg", cap_seg[0], 7'h7F);
    check("lz d1 seg", cap_seg[1], 7'h7F);
    check("lz d2 seg", cap_seg[2], 7'h12);
    check("lz d3 seg", cap_seg[3], 7'h40);
    check("lz d0 dp", cap_dp[0], 0);
    check("lz d1 dp", cap_dp[1], 1);
    check("u1 no pend no frame", frm[1], 0);
    BCD = 16'h0000; DP = 4'b0001; Load = 1'b1;
    step();
    Load = 1'b0;
    wait_frame(1, 100);
    scan_u1();
    for (int k = 0; k < 3; k++) check($sformatf("zero d%0d seg", k), cap_seg[k], 7'h7F);
    check("zero d3 seg", cap_seg[3], 7'h40);
    check("zero d0 dp", cap_dp[0], 0);
    nfr = 0;
    for (int j = 0; j < 16; j++) begin
      step();
      for (int i = 0; i < ND; i++) if (frm[i]) nfr++;
    end
    check("idle frames", nfr, 0);
    while (edges % 4 != 1) step();
    BCD = 16'h1111; DP = 4'b0000; Load = 1'b1;
    step();
    Load = 1'b0;
    for (int n = 0; n < 8 && !frm[0]; n++) begin check("hold seg", seg[0], 7'h40); step(); end
    check("hold seg", seg[0], 7'h40);
    check("u0 mid-frame load frame", frm[0], 1);
    step();
    check("new seg", seg[0], 7'h79);
    while ((edges + 1) % 4 != 0) step();
    BCD = 16'h2222; Load = 1'b1;
    step();
    Load = 1'b0;
    check("u0 boundary load frame", frm[0], 1);
    step();
    check("boundary new seg", seg[0], 7'h24);
    BCD = 16'h8888; DP = 4'b0000; Load = 1'b1;
    step();
    Load = 1'b0;
    wait_frame(2, 40);
    step();
    check("pol seg", seg[2], 7'h7F);
    check("pol sg", sg[2], 4'b1110);
    repeat (5) step();
    #3 nCR = 1'b0;
    #1 check_reset();
    model_reset();
    #2 nCR = 1'b1;
    repeat (20) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
